// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: frame-buffer port controller between the SPI pixel receiver
// and a single-port synchronous pixel memory. Scan reads always win the memory;
// queued writes and frame-clear writes drain in the cycles reads leave idle.
module fb_write_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int PIX_W       = 2,
  parameter int FRAME_WORDS = 12288,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          mainClk,
  input  logic                          reset,
  input  logic                          wrValid,
  input  logic                          wrBurst,
  input  logic [ADDR_W-1:0]             wrAddr,
  input  logic [PIX_W-1:0]              wrData,
  output logic                          wrReady,
  input  logic                          rdReq,
  input  logic [ADDR_W-1:0]             rdAddr,
  output logic                          rdValid,
  output logic [PIX_W-1:0]              rdData,
  input  logic                          clearReq,
  input  logic [PIX_W-1:0]              clearVal,
  output logic                          clearBusy,
  output logic                          clearDone,
  output logic                          dropped,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic [ADDR_W-1:0]             memAddr,
  output logic                          memWe,
  output logic [PIX_W-1:0]              memWData,
  input  logic [PIX_W-1:0]              memRData
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic                w_startClear;

  logic [ADDR_W-1:0]   r_fifoAddr [FIFO_DEPTH];
  logic [PIX_W-1:0]    r_fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_count;

  logic [ADDR_W-1:0]   r_burstPtr;
  logic [ADDR_W-1:0]   r_clearPtr;
  logic [ADDR_W-1:0]   r_lastAddr;
  logic [PIX_W-1:0]    r_clearVal;
  logic [PIX_W-1:0]    r_lastWData;
  logic [PIX_W-1:0]    r_fwdData;
  logic                r_pending;
  logic                r_rdValid;
  logic                r_fwdHit;
  logic                r_dropped;

  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_pushAddr;
  logic                w_clearAccept;
  logic                w_clearWrite;
  logic                w_clearLast;
  logic                w_fwdHit;
  logic [PIX_W-1:0]    w_fwdData;

  assign wrReady       = (r_count != FULL_COUNT) && (r_state == S_IDLE) && !r_pending;
  assign w_push        = wrValid && wrReady;
  assign w_pushAddr    = wrBurst ? r_burstPtr : wrAddr;
  assign w_pop         = !rdReq && (r_state == S_IDLE) && (r_count != '0);
  assign w_clearWrite  = !rdReq && (r_state == S_CLEAR);
  assign w_clearLast   = w_clearWrite && (r_clearPtr == LAST_ADDR);
  assign w_clearAccept = clearReq && (r_state == S_IDLE) && !r_pending;

  assign clearBusy = (r_state == S_CLEAR);
  assign clearDone = w_clearLast;
  assign dropped   = r_dropped;
  assign fifoCount = r_count;
  assign rdValid   = r_rdValid;
  assign rdData    = r_rdValid ? (r_fwdHit ? r_fwdData : memRData) : '0;

  // State register for the idle/clear sequencer.
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  // Next state: a clear starts only once no queued write can land after it.
  always_comb begin
    w_stateNext  = r_state;
    w_startClear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_clearAccept && (r_count == '0) && !w_push) ||
            (r_pending && (r_count == '0))) begin
          w_stateNext  = S_CLEAR;
          w_startClear = 1'b1;
        end
      end
      S_CLEAR: begin
        if (w_clearLast) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Clear bookkeeping: pending flag, sampled fill value and fill pointer.
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      r_pending  <= 1'b0;
      r_clearVal <= '0;
      r_clearPtr <= '0;
    end else begin
      if (w_startClear)       r_pending <= 1'b0;
      else if (w_clearAccept) r_pending <= 1'b1;
      if (w_clearAccept) r_clearVal <= clearVal;
      if (w_startClear)      r_clearPtr <= '0;
      else if (w_clearWrite) r_clearPtr <= (r_clearPtr == LAST_ADDR) ? '0 : r_clearPtr + 1'b1;
    end
  end

  // Write FIFO storage, pointers, occupancy, burst pointer and drop flag.
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifoAddr[i] <= '0;
        r_fifoData[i] <= '0;
      end
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_burstPtr <= '0;
      r_dropped  <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifoAddr[r_wrPtr] <= w_pushAddr;
        r_fifoData[r_wrPtr] <= wrData;
        r_wrPtr             <= r_wrPtr + 1'b1;
        r_burstPtr          <= (w_pushAddr == LAST_ADDR) ? '0 : w_pushAddr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (wrValid && !wrReady) r_dropped <= 1'b1;
    end
  end

  // Forwarding search: oldest to youngest queued entry, then this cycle's push.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = r_rdPtr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_fifoAddr[idx] == rdAddr)) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_fifoData[idx];
      end
    end
    if (w_push && (w_pushAddr == rdAddr)) begin
      w_fwdHit  = 1'b1;
      w_fwdData = wrData;
    end
  end

  // Memory port mux: scan read, then clear fill, then FIFO head, else hold.
  always_comb begin
    memAddr  = r_lastAddr;
    memWData = r_lastWData;
    memWe    = 1'b0;
    if (rdReq) begin
      memAddr = rdAddr;
    end else if (r_state == S_CLEAR) begin
      memAddr  = r_clearPtr;
      memWData = r_clearVal;
      memWe    = 1'b1;
    end else if (r_count != '0) begin
      memAddr  = r_fifoAddr[r_rdPtr];
      memWData = r_fifoData[r_rdPtr];
      memWe    = 1'b1;
    end
  end

  // Remember the last memory address/data and capture the read result source.
  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      r_lastAddr  <= '0;
      r_lastWData <= '0;
      r_rdValid   <= 1'b0;
      r_fwdHit    <= 1'b0;
      r_fwdData   <= '0;
    end else begin
      r_lastAddr  <= memAddr;
      r_lastWData <= memWData;
      r_rdValid   <= rdReq;
      r_fwdHit    <= rdReq && w_fwdHit && (r_state == S_IDLE);
      r_fwdData   <= w_fwdData;
    end
  end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Parametrised frame-buffer port controller between the SPI pixel receiver and a single-port synchronous pixel memory (SPRAM or EBR), all in the `mainClk` domain. It replaces the fixed single-write/single-read SPRAM path with the following:
- a write FIFO with backpressure;
- auto-incrementing burst addressing with frame wrap;
- read-after-write forwarding;
- a hardware frame-clear sequencer.

VGA scan reads always win memory access. Queued writes and clear writes drain in idle cycles.

## Interface
Parameters:
- `ADDR_W`, 14: pixel address width.
- `PIX_W`, 2: pixel data width.
- `FRAME_WORDS`, 12288: pixels per frame. Burst and clear addresses wrap at `FRAME_WORDS-1`. Must be ≤ 2^ADDR_W.
- `FIFO_DEPTH`, 4: write FIFO entries. Power of two, ≥2.

Ports:
- `mainClk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wrValid` in 1: write request.
- `wrBurst` in 1: 1 = use the internal burst pointer; 0 = use `wrAddr`.
- `wrAddr` in ADDR_W: explicit write address.
- `wrData` in PIX_W: write pixel.
- `wrReady` out 1: write will be accepted this cycle.
- `rdReq` in 1: scan read request.
- `rdAddr` in ADDR_W: read address.
- `rdValid` out 1: `rdData` valid.
- `rdData` out PIX_W: read pixel.
- `clearReq` in 1: single-cycle pulse; fill the frame with `clearVal`.
- `clearVal` in PIX_W: fill value, sampled on `clearReq`.
- `clearBusy` out 1: clear in progress.
- `clearDone` out 1: single-cycle pulse when the clear finishes.
- `dropped` out 1: sticky; a write was offered while `wrReady`=0.
- `fifoCount` out $clog2(FIFO_DEPTH)+1: queued writes.
- `memAddr` out ADDR_W: memory address.
- `memWe` out 1: memory write enable.
- `memWData` out PIX_W: memory write data.
- `memRData` in PIX_W: memory read data, valid 1 cycle after the address.

## Operation
- States: IDLE, CLEAR.
  - IDLE→CLEAR on `clearReq` when the FIFO is empty. If the FIFO is not empty, the request is held pending until the FIFO drains.
  - CLEAR→IDLE after the write to address `FRAME_WORDS-1`. `clearDone` pulses on that same cycle.
- `clearReq` while already busy or pending is ignored.
- `wrReady` = FIFO not full AND state IDLE AND no clear pending. It is a function of registers only, with no combinational path from `wrValid`.
- Accepted write (`wrValid`&`wrReady`): push {addr, data} into the FIFO.
  - `wrBurst`=1: addr = `burstPtr`.
  - `wrBurst`=0: addr = `wrAddr`.
  - `burstPtr` then becomes addr+1, or 0 if addr = `FRAME_WORDS-1`.
- Memory arbitration each cycle, in priority order:
  1. `rdReq`: `memAddr`=`rdAddr`, `memWe`=0.
  2. CLEAR: `memAddr`=`clearPtr`, `memWData`=clear value, `memWe`=1, `clearPtr`++.
  3. FIFO non-empty: write the head, pop.
  4. Otherwise `memWe`=0; `memAddr` holds its last value.
- Read forwarding: on `rdReq`, compare `rdAddr` against all valid FIFO entries, including one pushed in that same cycle.
  - On a match, the youngest matching entry's data is latched and returned instead of `memRData`.
  - Reads during CLEAR are not forwarded and return memory contents.
- `dropped` sets on `wrValid`&!`wrReady` and clears only on reset.
- Simultaneous push and pop: `fifoCount` is unchanged and data ordering is preserved.

## Timing
- Read latency is exactly 1: `rdReq` at cycle N gives `rdValid`=1 and `rdData` at N+1. Back-to-back reads give one result per cycle.
- Write visibility:
  - An entry pushed at N with no `rdReq` at N+1 reaches memory at N+1 (`memWe` high in N+1) if it is at the FIFO head.
  - A read of that address is correct from N onward, by forwarding or from memory.
- Clear duration is `FRAME_WORDS` non-read cycles. `clearBusy` rises the cycle after `clearReq` is accepted and falls with `clearDone`.
- Reset, asynchronous, applies to all registers. During and after reset until the first input:
  - 0: `rdValid`, `rdData`, `memWe`, `memAddr`, `memWData`, `clearBusy`, `clearDone`, `dropped`, `fifoCount`.
  - 1: `wrReady`.
  - Internally: FIFO empty, `burstPtr`=0, `clearPtr`=0, state IDLE.
- Reset mid-CLEAR or mid-drain abandons the operation: no `clearDone` and no further memory writes.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs at their listed reset values immediately. After release, `wrReady`=1 and `fifoCount`=0.
- Single write/read: write addr 0x0100 data 2'b11, with no reads for 2 cycles. Then `rdReq` 0x0100 → `rdValid`=1 and `rdData`=2'b11 on the next cycle.
- Burst wrap: explicit write to `FRAME_WORDS-2`, then 3 burst writes → memory writes land at `FRAME_WORDS-1`, 0, 1.
- Forwarding under starvation: hold `rdReq` continuously to addr 5 and write addr 5 data 2'b01 → `rdData`=2'b01 from the cycle after the write is accepted. `memWe` stays 0 while `rdReq` is held.
- Backpressure: hold `rdReq` and offer 6 writes with `FIFO_DEPTH`=4 → 4 accepted, `wrReady`=0, `dropped`=1, `fifoCount`=4. Release `rdReq` → 4 writes in order over 4 cycles.
- Clear: `clearReq` with `clearVal`=2'b10 and `FRAME_WORDS`=16 → 16 consecutive writes of 2'b10, `clearDone` on the 16th. Repeat, asserting `reset` at write 8 → writes stop and there is no `clearDone`.
